// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC cosine pipeline and its downstream stages.
package cordic_pkg;

  localparam int unsigned WORD_LENGTH_DEF  = 21;
  localparam int unsigned N_ITERATIONS_DEF = 17;

  // 1.0 in Q2.19
  localparam logic [20:0] ONE = 21'h080000;

  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StAccum = 1'b1;

endpackage

// File: rtl/cordic_tag_delay.sv
// Shift register of {valid, last} tags, as deep as the CORDIC pipeline latency.
module cordic_tag_delay
  import cordic_pkg::*;
#(
  parameter int unsigned DEPTH = N_ITERATIONS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  tag_t i_tag,
  output tag_t o_tag,
  output logic o_any_valid
);

  tag_t r_tags [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tags[i] <= '0;
      end
    end else begin
      r_tags[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_tags[i] <= r_tags[i-1];
      end
    end
  end

  always_comb begin
    o_any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      o_any_valid = o_any_valid | r_tags[i].valid;
    end
  end

  assign o_tag = r_tags[DEPTH-1];

endmodule

// File: rtl/cordic_accumulator.sv
// Sums consecutive CORDIC cosine samples into per-vector totals with a one-entry result register.
// Define CORDIC_ACC_SAT_EN for saturating adds and a sticky sat flag; otherwise adds wrap.
module cordic_accumulator
  import cordic_pkg::*;
#(
  parameter int unsigned WORD_LENGTH  = WORD_LENGTH_DEF,
  parameter int unsigned N_ITERATIONS = N_ITERATIONS_DEF,
  parameter int unsigned ACC_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [WORD_LENGTH-1:0] sample,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_sum,
  output logic [15:0]            out_count,
  output logic                   busy,
  output logic                   dropped,
  output logic                   sat
);

  tag_t                 w_tag_in;
  tag_t                 w_tag_out;
  logic                 w_tags_busy;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH-1:0] w_sum;
  logic [15:0]          w_cnt_inc;
  logic                 w_load;

  logic [0:0]           r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [15:0]          r_cnt;
  logic                 r_out_valid;
  logic [ACC_WIDTH-1:0] r_out_sum;
  logic [15:0]          r_out_count;
  logic                 r_dropped;

  assign w_tag_in = '{valid: in_valid, last: in_valid & in_last};

  cordic_tag_delay #(
    .DEPTH(N_ITERATIONS)
  ) u_tag_delay (
    .clk        (clk),
    .rst        (rst),
    .i_tag      (w_tag_in),
    .o_tag      (w_tag_out),
    .o_any_valid(w_tags_busy)
  );

  assign w_ext     = ACC_WIDTH'($signed(sample));
  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  assign w_load    = w_tag_out.valid & w_tag_out.last;

`ifdef CORDIC_ACC_SAT_EN
  logic [ACC_WIDTH:0] w_wide;
  logic               w_ovf;
  logic               r_sat;

  // One guard bit: overflow when the two top bits of the widened sum disagree
  assign w_wide = {r_acc[ACC_WIDTH-1], r_acc} + {w_ext[ACC_WIDTH-1], w_ext};
  assign w_ovf  = w_wide[ACC_WIDTH] ^ w_wide[ACC_WIDTH-1];
  assign w_sum  = !w_ovf ? w_wide[ACC_WIDTH-1:0] :
                  w_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} :
                                      {1'b0, {(ACC_WIDTH-1){1'b1}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else if (w_tag_out.valid && w_ovf) begin
      r_sat <= 1'b1;
    end
  end

  assign sat = r_sat;
`else
  assign w_sum = r_acc + w_ext;
  assign sat   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_dropped   <= 1'b0;
    end else begin
      if (w_tag_out.valid) begin
        if (w_tag_out.last) begin
          r_state <= StIdle;
          r_acc   <= '0;
          r_cnt   <= '0;
        end else begin
          r_state <= StAccum;
          r_acc   <= w_sum;
          r_cnt   <= w_cnt_inc;
        end
      end
      // A load beats a simultaneous handshake; a load into a stalled full register is lost
      if (w_load) begin
        if (!r_out_valid || out_ready) begin
          r_out_valid <= 1'b1;
          r_out_sum   <= w_sum;
          r_out_count <= w_cnt_inc;
        end else begin
          r_dropped <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;
  assign dropped   = r_dropped;
  assign busy      = w_tags_busy | (r_state == StAccum) | r_out_valid;

endmodule

// File: tb/tb_cordic_accumulator.sv
// Directed bench for cordic_accumulator; models the CORDIC pipeline as a pure delay line.
module tb_cordic_accumulator;

  localparam int N = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [20:0] in_val = '0;
  logic [20:0] sample;
  logic [20:0] pipe [N];

  logic        out_valid, busy, dropped, sat;
  logic [31:0] out_sum;
  logic [15:0] out_count;
  logic        out_valid_w, busy_w, dropped_w, sat_w;
  logic [21:0] out_sum_w;
  logic [15:0] out_count_w;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    pipe[0] <= in_val;
    for (int i = 1; i < N; i++) pipe[i] <= pipe[i-1];
  end
  assign sample = pipe[N-1];

  cordic_accumulator #(.WORD_LENGTH(21), .N_ITERATIONS(N), .ACC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .sample(sample),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_count(out_count),
    .busy(busy), .dropped(dropped), .sat(sat)
  );

  cordic_accumulator #(.WORD_LENGTH(21), .N_ITERATIONS(N), .ACC_WIDTH(22)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .sample(sample),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_sum(out_sum_w),
    .out_count(out_count_w), .busy(busy_w), .dropped(dropped_w), .sat(sat_w)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [20:0] val);
    @(posedge clk);
    #1;
    in_valid = v;
    in_last  = l;
    in_val   = val;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic at_cycle(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic wait_valid(input string name, output int t, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    t = cyc;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: out_valid never rose, got 0 expected 1", name);
    end
  endtask

  typedef struct {
    int               len;
    logic [3:0][20:0] v;
    logic [31:0]      sum;
    logic [15:0]      cnt;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int  k, t;
    bit  ok;
    logic [21:0] exp_w;
    logic        exp_sat_w;

    tbl[0] = '{len: 4, v: {4{21'h080000}}, sum: 32'h0020_0000, cnt: 16'd4};
    tbl[1] = '{len: 1, v: {21'h0, 21'h0, 21'h0, 21'h080000}, sum: 32'h0008_0000, cnt: 16'd1};
    tbl[2] = '{len: 2, v: {21'h0, 21'h0, 21'h040000, 21'h040000}, sum: 32'h0008_0000,
               cnt: 16'd2};
    tbl[3] = '{len: 3, v: {21'h0, {3{21'h180000}}}, sum: 32'hFFE8_0000, cnt: 16'd3};
    tbl[4] = '{len: 2, v: {21'h0, 21'h0, 21'h180000, 21'h080000}, sum: 32'h0, cnt: 16'd2};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_sum", out_sum, 32'd0);
    chk("rst_out_count", {16'b0, out_count}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_dropped", {31'b0, dropped}, 32'd0);
    chk("rst_sat", {31'b0, sat}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      for (int e = 0; e < tbl[i].len; e++) drive(1'b1, e == tbl[i].len - 1, tbl[i].v[e]);
      k = cyc;
      drive(1'b0, 1'b0, 21'h0);
      wait_valid($sformatf("vec%0d_valid", i), t, ok);
      if (ok) begin
        chk($sformatf("vec%0d_latency", i), t - k, N + 1);
        chk($sformatf("vec%0d_sum", i), out_sum, tbl[i].sum);
        chk($sformatf("vec%0d_count", i), {16'b0, out_count}, {16'b0, tbl[i].cnt});
        chk($sformatf("vec%0d_busy", i), {31'b0, busy}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("vec%0d_hs_valid", i), {31'b0, out_valid}, 32'd0);
        chk($sformatf("vec%0d_idle_busy", i), {31'b0, busy}, 32'd0);
      end
    end

    // Back-to-back vectors with the consumer always ready
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 21'h080000);
    k = cyc;
    drive(1'b1, 1'b0, 21'h040000);
    drive(1'b1, 1'b1, 21'h040000);
    drive(1'b0, 1'b0, 21'h0);
    at_cycle(k + 18);
    chk("b2b_v0", {31'b0, out_valid}, 32'd1);
    chk("b2b_sum0", out_sum, 32'h0008_0000);
    chk("b2b_cnt0", {16'b0, out_count}, 32'd1);
    at_cycle(k + 19);
    chk("b2b_gap", {31'b0, out_valid}, 32'd0);
    at_cycle(k + 20);
    chk("b2b_v1", {31'b0, out_valid}, 32'd1);
    chk("b2b_sum1", out_sum, 32'h0008_0000);
    chk("b2b_cnt1", {16'b0, out_count}, 32'd2);
    at_cycle(k + 21);
    chk("b2b_done", {31'b0, out_valid}, 32'd0);

    // Load and handshake in the same cycle
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 21'h080000);
    k = cyc;
    drive(1'b1, 1'b1, 21'h040000);
    drive(1'b0, 1'b0, 21'h0);
    at_cycle(k + 18);
    chk("same_sum0", out_sum, 32'h0008_0000);
    at_cycle(k + 19);
    chk("same_valid", {31'b0, out_valid}, 32'd1);
    chk("same_sum1", out_sum, 32'h0004_0000);
    chk("same_dropped", {31'b0, dropped}, 32'd0);
    at_cycle(k + 20);
    chk("same_done", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Stalled consumer: second sum is lost
    do_reset();
    drive(1'b1, 1'b1, 21'h080000);
    k = cyc;
    drive(1'b0, 1'b0, 21'h0);
    drive(1'b1, 1'b1, 21'h040000);
    drive(1'b0, 1'b0, 21'h0);
    at_cycle(k + 18);
    chk("drop_v0", {31'b0, out_valid}, 32'd1);
    chk("drop_pre", {31'b0, dropped}, 32'd0);
    at_cycle(k + 21);
    chk("drop_valid", {31'b0, out_valid}, 32'd1);
    chk("drop_sum", out_sum, 32'h0008_0000);
    chk("drop_cnt", {16'b0, out_count}, 32'd1);
    chk("drop_flag", {31'b0, dropped}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("drop_hs", {31'b0, out_valid}, 32'd0);
    chk("drop_sticky", {31'b0, dropped}, 32'd1);

    // Reset while tags are in flight
    do_reset();
    drive(1'b1, 1'b0, 21'h040000);
    k = cyc;
    drive(1'b1, 1'b0, 21'h040000);
    drive(1'b1, 1'b0, 21'h040000);
    while (cyc < k + 10) drive(1'b0, 1'b0, 21'h0);
    chk("mid_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    at_cycle(k + 22);
    chk("mid_stale", {31'b0, out_valid}, 32'd0);
    drive(1'b1, 1'b1, 21'h040000);
    drive(1'b0, 1'b0, 21'h0);
    wait_valid("mid_after", t, ok);
    if (ok) begin
      chk("mid_sum", out_sum, 32'h0004_0000);
      chk("mid_cnt", {16'b0, out_count}, 32'd1);
    end

    // Narrow accumulator overflow
    do_reset();
    drive(1'b1, 1'b0, 21'h0FFFFF);
    drive(1'b1, 1'b0, 21'h0FFFFF);
    drive(1'b1, 1'b1, 21'h0FFFFF);
    drive(1'b0, 1'b0, 21'h0);
`ifdef CORDIC_ACC_SAT_EN
    exp_w = 22'h1FFFFF;
    exp_sat_w = 1'b1;
`else
    exp_w = 22'h2FFFFD;
    exp_sat_w = 1'b0;
`endif
    wait_valid("wide_valid", t, ok);
    if (ok) begin
      chk("narrow_valid", {31'b0, out_valid_w}, 32'd1);
      chk("narrow_sum", {10'b0, out_sum_w}, {10'b0, exp_w});
      chk("narrow_sat", {31'b0, sat_w}, {31'b0, exp_sat_w});
      chk("narrow_cnt", {16'b0, out_count_w}, 32'd3);
      chk("wide_sum", out_sum, 32'h002F_FFFD);
      chk("wide_sat", {31'b0, sat}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
